// File: rtl/cic_interp_integrator.sv
// Integrator back end of the CIC interpolator.
// Low-rate comb samples arrive over a valid/ready handshake. Each sample is
// zero-stuffed by RATE and passed through STAGES cascaded integrators that
// advance once per clk_en tick. The last integrator is the full-width output,
// and its top OUT_WIDTH bits are the truncated output word.
module cic_interp_integrator #(
  parameter int IN_WIDTH  = 24,
  parameter int RATE      = 8,
  parameter int STAGES    = 3,
  parameter int ACC_WIDTH = IN_WIDTH + (STAGES - 1) * $clog2(RATE),
  parameter int OUT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_en,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic [ACC_WIDTH-1:0] out_full,
  output logic                 out_valid,
  output logic                 underrun
);

  localparam int PH_W = $clog2(RATE);

  logic [PH_W-1:0]      phase_q, phase_d;
  logic [ACC_WIDTH-1:0] acc_q [STAGES];
  logic [ACC_WIDTH-1:0] acc_d [STAGES];
  logic                 out_valid_q;
  logic                 underrun_q, underrun_d;

  logic                 phase_zero;
  logic                 take;
  logic [ACC_WIDTH-1:0] x;

  // A new sample is only taken on a phase-0 tick; every other tick feeds zero.
  assign phase_zero = (phase_q == '0);
  assign in_ready   = clk_en & phase_zero & ~rst;
  assign take       = in_valid & in_ready;
  assign x          = take ? ACC_WIDTH'($signed(in_data)) : '0;

  // Next-state for phase, underrun flag and the integrator cascade.
  always_comb begin
    // NOTE: every signal gets a hold-value default first, so no path leaves
    // it unassigned and no latch is inferred.
    phase_d    = phase_q;
    underrun_d = underrun_q;
    acc_d      = acc_q;
    if (clk_en) begin
      // RATE is a power of two, so the counter wraps RATE-1 -> 0 naturally.
      phase_d = phase_q + PH_W'(1);
      if (phase_zero && !in_valid) begin
        underrun_d = 1'b1;
      end
      // Each stage adds the pre-update value of the stage before it; the
      // sums wrap modulo 2^ACC_WIDTH, which the comb section depends on.
      acc_d[0] = acc_q[0] + x;
      for (int k = 1; k < STAGES; k++) begin
        acc_d[k] = acc_q[k] + acc_q[k-1];
      end
    end
  end

  // State registers; rst overrides clk_en and clears everything.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values of the others, giving one register per stage.
    if (rst) begin
      phase_q     <= '0;
      out_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
      // NOTE: the integrator array is a handful of registers, not a RAM, and
      // must start from zero, so it is cleared element by element on reset.
      for (int k = 0; k < STAGES; k++) begin
        acc_q[k] <= '0;
      end
    end else begin
      phase_q     <= phase_d;
      out_valid_q <= clk_en;
      underrun_q  <= underrun_d;
      acc_q       <= acc_d;
    end
  end

  // The last integrator register is the output; it holds between ticks.
  assign out_full  = acc_q[STAGES-1];
  assign out_data  = acc_q[STAGES-1][ACC_WIDTH-1 -: OUT_WIDTH];
  assign out_valid = out_valid_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_cic_interp_integrator.sv
// Randomized self-checking bench for cic_interp_integrator.
// The reference model treats the cascade as a filter: after tick n the output
// is sum_j x_j * C(n-j, STAGES-1), taken modulo 2^ACC_WIDTH, where x_j is the
// zero-stuffed integrator input on tick j.
module tb_cic_interp_integrator;

  localparam int IN_W   = 24;
  localparam int RATE   = 4;
  localparam int STAGES = 3;
  localparam int ACC_W  = IN_W + (STAGES - 1) * $clog2(RATE);
  localparam int OUT_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              clk_en;
  logic [IN_W-1:0]   in_data;
  logic              in_valid;
  logic              in_ready;
  logic [OUT_W-1:0]  out_data;
  logic [ACC_W-1:0]  out_full;
  logic              out_valid;
  logic              underrun;

  // Second instance: single stage, RATE=2, no growth, for the wrap-around case.
  logic              w_rst;
  logic              w_en;
  logic [23:0]       w_data;
  logic              w_valid;
  logic              w_ready;
  logic [15:0]       w_out_data;
  logic [23:0]       w_out_full;
  logic              w_out_valid;
  logic              w_underrun;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  longint           xs[$];
  int               m_phase;
  logic             m_underrun;
  logic [ACC_W-1:0] m_out;

  always #5 clk = ~clk;

  cic_interp_integrator #(
    .IN_WIDTH (IN_W),
    .RATE     (RATE),
    .STAGES   (STAGES),
    .OUT_WIDTH(OUT_W)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .clk_en   (clk_en),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_full (out_full),
    .out_valid(out_valid),
    .underrun (underrun)
  );

  cic_interp_integrator #(
    .IN_WIDTH (24),
    .RATE     (2),
    .STAGES   (1),
    .OUT_WIDTH(16)
  ) u_wrap (
    .clk      (clk),
    .rst      (w_rst),
    .clk_en   (w_en),
    .in_data  (w_data),
    .in_valid (w_valid),
    .in_ready (w_ready),
    .out_data (w_out_data),
    .out_full (w_out_full),
    .out_valid(w_out_valid),
    .underrun (w_underrun)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint binom(input longint m, input int k);
    longint c = 1;
    for (int i = 0; i < k; i++) c = c * (m - i) / (i + 1);
    return c;
  endfunction

  // Expected final-stage value after the most recent tick.
  function automatic logic [ACC_W-1:0] model_out();
    longint sum = 0;
    longint n = longint'(xs.size()) - 1;
    for (int j = 0; j < xs.size(); j++) sum += xs[j] * binom(n - j, STAGES - 1);
    return ACC_W'(sum);
  endfunction

  // One clock cycle on the main DUT; entered and left 1 time unit after posedge.
  task automatic step(input logic en, input logic v, input logic [IN_W-1:0] d,
                      output logic rdy_seen);
    logic exp_ready;
    longint x;
    clk_en   = en;
    in_valid = v;
    in_data  = d;
    #2;
    exp_ready = en && (m_phase == 0);
    rdy_seen  = in_ready;
    check("in_ready", in_ready, exp_ready);
    if (en) begin
      x = 0;
      if (m_phase == 0) begin
        if (v) x = longint'($signed(d));
        else   m_underrun = 1'b1;
      end
      xs.push_back(x);
      m_phase = (m_phase + 1) % RATE;
      m_out   = model_out();
    end
    @(posedge clk);
    #1;
    check("out_valid", out_valid, en);
    check("out_full", out_full, m_out);
    check("out_data", out_data, m_out[ACC_W-1 -: OUT_W]);
    check("underrun", underrun, m_underrun);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    clk_en   = 1'b1;
    in_valid = 1'b1;
    #2;
    check("ready_in_rst", in_ready, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    clk_en   = 1'b0;
    in_valid = 1'b0;
    xs.delete();
    m_phase    = 0;
    m_underrun = 1'b0;
    m_out      = '0;
    check("rst_out_full", out_full, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_underrun", underrun, 0);
  endtask

  // Impulse of 1 then zeros; clk_en every `period` cycles.
  task automatic impulse_run(input int period, input string tag);
    logic [ACC_W-1:0] tab [7] = '{0, 0, 1, 3, 6, 10, 15};
    logic got_first = 1'b0;
    logic rdy;
    int   tick = 0;
    for (int c = 0; c < 7 * period; c++) begin
      logic en = (c % period == 0);
      step(en, 1'b1, got_first ? '0 : IN_W'(1), rdy);
      if (rdy) got_first = 1'b1;
      if (en) begin
        check(tag, out_full, tab[tick]);
        check({tag, "_ready"}, rdy, (tick % RATE) == 0);
        tick++;
      end
    end
  endtask

  initial begin
    logic rdy;
    int   pulses;
    logic pending;
    logic [IN_W-1:0] pdata;

    w_rst = 1'b1; w_en = 1'b0; w_valid = 1'b0; w_data = '0;
    rst = 1'b1; clk_en = 1'b0; in_valid = 1'b0; in_data = '0;
    @(posedge clk);
    #1;

    // Reset and impulse at full rate.
    do_reset();
    impulse_run(1, "imp_full");

    // Reset mid-stream with nonzero accumulators.
    do_reset();
    step(1'b1, 1'b1, 24'h000123, rdy);
    check("first_ready_after_rst", rdy, 1'b1);

    // Handshake: a sample offered at phase 2 waits for phase 0.
    do_reset();
    step(1'b1, 1'b1, IN_W'(3), rdy);
    step(1'b1, 1'b0, '0, rdy);
    pulses = 0;
    for (int t = 2; t <= 4; t++) begin
      step(1'b1, 1'b1, IN_W'(5), rdy);
      if (rdy) pulses++;
    end
    check("hs_one_pulse", pulses, 1);
    check("hs_no_underrun", underrun, 1'b0);

    // Underrun: phase-0 tick with no valid input; sticky through transfers.
    for (int t = 5; t <= 8; t++) step(1'b1, 1'b0, '0, rdy);
    check("underrun_set", underrun, 1'b1);
    for (int t = 9; t <= 20; t++) step(1'b1, 1'b1, IN_W'($urandom), rdy);
    check("underrun_sticky", underrun, 1'b1);

    // clk_en every third cycle.
    do_reset();
    impulse_run(3, "imp_gated");

    // Randomized traffic with a mid-run reset.
    do_reset();
    pending = 1'b0;
    pdata   = '0;
    for (int c = 0; c < 800; c++) begin
      if (c == 400) begin
        do_reset();
        check("rst_phase_ready", in_ready, 1'b0);
      end
      if (!pending && ($urandom % 5 != 0)) begin
        pending = 1'b1;
        pdata   = IN_W'($urandom);
      end
      step(($urandom % 3) != 0, pending, pdata, rdy);
      if (rdy && pending) pending = 1'b0;
    end

    // Wrap-around on the single-stage instance.
    w_rst   = 1'b0;
    w_en    = 1'b1;
    w_valid = 1'b1;
    w_data  = 24'h7FFFFF;
    #2;
    check("wrap_ready0", w_ready, 1'b1);
    @(posedge clk);
    #1;
    check("wrap_full0", w_out_full, 24'h7FFFFF);
    check("wrap_data0", w_out_data, 16'h7FFF);
    #2;
    check("wrap_ready1", w_ready, 1'b0);
    @(posedge clk);
    #1;
    check("wrap_full1", w_out_full, 24'h7FFFFF);
    @(posedge clk);
    #1;
    check("wrap_full2", w_out_full, 24'hFFFFFE);
    check("wrap_data2", w_out_data, 16'hFFFF);
    check("wrap_valid", w_out_valid, 1'b1);
    check("wrap_underrun", w_underrun, 1'b0);
    w_en    = 1'b0;
    w_valid = 1'b0;
    @(posedge clk);
    #1;
    check("wrap_hold", w_out_full, 24'hFFFFFE);
    check("wrap_valid_low", w_out_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
